module_seg_scan_driver: RTL and testbench



---
 rtl/seg_pkg.sv | 18 +
 rtl/seg_hex_rom.sv | 12 +
 rtl/module_seg_scan_driver.sv | 81 ++++++++
 tb/tb_module_seg_scan_driver.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan driver family.
// Segment bit order is {a,b,c,d,e,f,g}, active-high.
package seg_pkg;

    typedef logic [6:0] seg_t;

    typedef enum logic {PH_DEAD, PH_ON} phase_t;

    localparam seg_t SEG_BLANK = 7'b0000000;

    localparam seg_t SEG_HEX [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

endpackage

// File: rtl/seg_hex_rom.sv
// Combinational hex nibble to seven-segment lookup; usable standalone by
// single-digit displays.
module seg_hex_rom
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output seg_t       seg
);

    assign seg = SEG_HEX[nib];

endmodule

// File: rtl/module_seg_scan_driver.sv
// Multiplexed N-digit seven-segment driver with per-slot anode dead time.
// Optional leading-zero blanking is enabled by defining SEG_LEADING_ZERO_BLANK_EN.
module module_seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned N_DIGITS    = 4,
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned DEAD_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_i,
    input  logic [4*N_DIGITS-1:0]   value_i,
    output logic [6:0]              seg_o,
    output logic [N_DIGITS-1:0]     an_o
);

    localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam phase_t PH_RESET = (DEAD_CYCLES == 0) ? PH_ON : PH_DEAD;

    logic [PW-1:0]         pre, pre_nxt;
    logic [IW-1:0]         idx, idx_nxt;
    logic [4*N_DIGITS-1:0] shadow;
    phase_t                phase, phase_nxt;
    logic                  wrap;
    logic [3:0]            nib;
    seg_t                  rom_seg, seg_nxt;
    logic [N_DIGITS-1:0]   an_nxt;

    seg_hex_rom u_rom (
        .nib (nib),
        .seg (rom_seg)
    );

    always_comb begin
        wrap      = (pre == PW'(REFRESH_DIV - 1));
        pre_nxt   = wrap ? '0 : pre + PW'(1);
        idx_nxt   = idx;
        if (wrap)
            idx_nxt = (idx == IW'(N_DIGITS - 1)) ? '0 : idx + IW'(1);
        // Phase is tracked against the prescaler value it will hold next cycle.
        phase_nxt = (32'(pre_nxt) < DEAD_CYCLES) ? PH_DEAD : PH_ON;
        nib       = shadow[{idx, 2'b00} +: 4];
        an_nxt    = (phase == PH_DEAD) ? '1 : ~(N_DIGITS'(1) << idx);
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic blank;

    always_comb begin
        blank = 1'b0;
        for (int unsigned k = 1; k < N_DIGITS; k++)
            if (idx == IW'(k) && (shadow >> (4 * k)) == '0)
                blank = 1'b1;
        seg_nxt = blank ? SEG_BLANK : rom_seg;
    end
`else
    assign seg_nxt = rom_seg;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre    <= '0;
            idx    <= '0;
            shadow <= '0;
            phase  <= PH_RESET;
            seg_o  <= SEG_BLANK;
            an_o   <= '1;
        end else begin
            pre   <= pre_nxt;
            idx   <= idx_nxt;
            phase <= phase_nxt;
            if (load_i)
                shadow <= value_i;
            seg_o <= seg_nxt;
            an_o  <= an_nxt;
        end
    end

endmodule

// File: tb/tb_module_seg_scan_driver.sv
// Directed scoreboard bench: a 4-digit instance (DIV=8, DEAD=2) and a
// 1-digit instance (DIV=4, DEAD=0) driven from the same clock/reset/load.
module tb_module_seg_scan_driver;

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] an;
        logic [6:0] seg1;
        logic       an1;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_i = 1'b0;
    logic [15:0] value_i = '0;
    logic [6:0]  seg_o, seg1_o;
    logic [3:0]  an_o;
    logic [0:0]  an1_o;

    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned cnt = 0;
    logic [15:0] m_shadow = '0;
    exp_t        sb[$];

    always #5 clk = ~clk;

    module_seg_scan_driver #(.N_DIGITS(4), .REFRESH_DIV(8), .DEAD_CYCLES(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load_i),
        .value_i (value_i),
        .seg_o   (seg_o),
        .an_o    (an_o)
    );

    module_seg_scan_driver #(.N_DIGITS(1), .REFRESH_DIV(4), .DEAD_CYCLES(0)) dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load_i),
        .value_i (value_i[3:0]),
        .seg_o   (seg1_o),
        .an_o    (an1_o)
    );

    function automatic logic [6:0] hexseg(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1111110;  4'h1: return 7'b0110000;
            4'h2: return 7'b1101101;  4'h3: return 7'b1111001;
            4'h4: return 7'b0110011;  4'h5: return 7'b1011011;
            4'h6: return 7'b1011111;  4'h7: return 7'b1110000;
            4'h8: return 7'b1111111;  4'h9: return 7'b1111011;
            4'hA: return 7'b1110111;  4'hB: return 7'b0011111;
            4'hC: return 7'b1001110;  4'hD: return 7'b0111101;
            4'hE: return 7'b1001111;  default: return 7'b1000111;
        endcase
    endfunction

    task automatic step(input logic r, input logic ld, input logic [15:0] v);
        exp_t e;
        exp_t got;
        int   pos, id;
        logic [15:0] hi;
        @(negedge clk);
        rst_n = r; load_i = ld; value_i = v;
        if (!r) begin
            e = '{seg: 7'b0, an: 4'b1111, seg1: 7'b0, an1: 1'b1};
        end else begin
            pos = int'(cnt % 8);
            id  = int'((cnt / 8) % 4);
            e.an  = (pos < 2) ? 4'b1111 : ~(4'b0001 << id);
            e.seg = hexseg(m_shadow[id*4 +: 4]);
`ifdef SEG_LEADING_ZERO_BLANK_EN
            hi = m_shadow >> (4 * id);
            if (id > 0 && hi == 16'h0) e.seg = 7'b0;
`else
            hi = '0;
`endif
            e.seg1 = hexseg(m_shadow[3:0]);
            e.an1  = 1'b0;
        end
        sb.push_back(e);
        if (!r) begin
            cnt = 0; m_shadow = '0;
        end else begin
            if (ld) m_shadow = v;
            cnt++;
        end
        @(posedge clk);
        #1;
        e = sb.pop_front();
        got = '{seg: seg_o, an: an_o, seg1: seg1_o, an1: an1_o[0]};
        tests++;
        assert (got.seg === e.seg) else begin
            fails++; $error("FAIL seg cyc=%0d got=%b exp=%b", cnt, got.seg, e.seg);
        end
        tests++;
        assert (got.an === e.an) else begin
            fails++; $error("FAIL an cyc=%0d got=%b exp=%b", cnt, got.an, e.an);
        end
        tests++;
        assert (got.seg1 === e.seg1) else begin
            fails++; $error("FAIL seg1 cyc=%0d got=%b exp=%b", cnt, got.seg1, e.seg1);
        end
        tests++;
        assert (got.an1 === e.an1) else begin
            fails++; $error("FAIL an1 cyc=%0d got=%b exp=%b", cnt, got.an1, e.an1);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++)
            step(1'b1, 1'b0, 16'($urandom));
    endtask

    initial begin
        // reset, including a load that must be discarded
        step(1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b1, 16'hFFFF);
        run(8);
        // scan with 1234
        step(1'b1, 1'b1, 16'h1234);
        run(40);
        // hex letters
        step(1'b1, 1'b1, 16'hABCD);
        run(32);
        // mid-slot load during digit1 ON
        while ((cnt % 32) != 11) run(1);
        step(1'b1, 1'b1, 16'h00F0);
        run(8);
        // blanking pattern, then all zeros
        step(1'b1, 1'b1, 16'h0070);
        run(32);
        step(1'b1, 1'b1, 16'h0000);
        run(32);
        // reset mid-slot with a coincident load
        step(1'b1, 1'b1, 16'h4321);
        while ((cnt % 32) != 20) run(1);
        step(1'b0, 1'b1, 16'h5555);
        run(20);
        // load coinciding with the prescaler wrap
        step(1'b1, 1'b1, 16'h8421);
        while ((cnt % 8) != 7) run(1);
        step(1'b1, 1'b1, 16'h9876);
        run(16);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
